fifo_rd_rst_sequencer: RTL and testbench

// - Read-domain reset sequencer for the clock-crossing FIFO.
// - Drives the async clear of the read-side gray-pointer synchronizer flops.
// - Gates read enable and reports reset-busy status.
// - Handshakes with the write-domain reset logic so that clears are released

---
 rtl/fifo_rst_pkg.sv | 27 ++
 rtl/fifo_bit_synchronizer.sv | 29 ++
 rtl/fifo_rd_rst_sequencer.sv | 144 ++++++++++++++
 tb/tb_fifo_rd_rst_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rst_pkg.sv
// Shared definitions for the FIFO read-domain reset sequencer.
// State encodings, parameter defaults and a sizing helper.
package fifo_rst_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ASSERT   = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    localparam int DEF_HOLD_CYCLES = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_TIMEOUT     = 256;

    typedef enum logic [1:0] {
        S_IDLE     = ST_IDLE,
        S_ASSERT   = ST_ASSERT,
        S_WAIT_ACK = ST_WAIT_ACK,
        S_RELEASE  = ST_RELEASE
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/fifo_bit_synchronizer.sv
// Single-bit multi-flop synchronizer with async active-low clear.
// Flops clear to 0 so a reset looks like a deasserted level.
module fifo_bit_synchronizer
    import fifo_rst_pkg::*;
#(
    parameter int C_SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [C_SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < C_SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[C_SYNC_STAGES-1];

endmodule

// File: rtl/fifo_rd_rst_sequencer.sv
// Read-domain reset sequencer: holds the synchronizer clear, waits for the
// write domain, then flushes the synchronizers before reopening reads.
module fifo_rd_rst_sequencer
    import fifo_rst_pkg::*;
#(
    parameter int C_HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int C_SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int C_TIMEOUT     = DEF_TIMEOUT
) (
    input  logic s_aclk,
    input  logic s_aresetn,
    input  logic wr_rst_req_async,
    input  logic wr_rst_ack_async,
    input  logic sw_rst_req,
    output logic sync_clr,
    output logic rd_rst_busy,
    output logic rd_en_gate,
    output logic rst_done,
    output logic err_timeout
);

    localparam int CNT_MAX =
        max3(C_HOLD_CYCLES, C_TIMEOUT, C_SYNC_STAGES + 1);
    localparam int CNT_W = $clog2(CNT_MAX) + 1;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t HOLD_LAST = cnt_t'(C_HOLD_CYCLES - 1);
    localparam cnt_t TO_LAST   = cnt_t'(C_TIMEOUT - 1);
    localparam cnt_t REL_LAST  = cnt_t'(C_SYNC_STAGES);

    state_e state_q, state_d;
    cnt_t   cnt_q, cnt_d, cnt_inc;
    logic   req_s, ack_s, req_dly_q;
    logic   req_evt;
    logic   clr_q, clr_d;
    logic   busy_q, busy_d;
    logic   gate_q, gate_d;
    logic   done_q, done_d;
    logic   err_q, err_d;

    fifo_bit_synchronizer #(
        .C_SYNC_STAGES(C_SYNC_STAGES)
    ) u_req_sync (
        .clk_i (s_aclk),
        .rst_ni(s_aresetn),
        .d_i   (wr_rst_req_async),
        .q_o   (req_s)
    );

    fifo_bit_synchronizer #(
        .C_SYNC_STAGES(C_SYNC_STAGES)
    ) u_ack_sync (
        .clk_i (s_aclk),
        .rst_ni(s_aresetn),
        .d_i   (wr_rst_ack_async),
        .q_o   (ack_s)
    );

    assign req_evt = (req_s & ~req_dly_q) | sw_rst_req;
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + cnt_t'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc;
        err_d   = err_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (req_evt) begin
                    state_d = S_ASSERT;
                    err_d   = 1'b0;
                end
            end
            S_ASSERT: begin
                if (req_evt) begin
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = S_WAIT_ACK;
                    cnt_d   = '0;
                end
            end
            S_WAIT_ACK: begin
                if (ack_s && !req_s) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end
            end
            S_RELEASE: begin
                if (req_evt) begin
                    state_d = S_ASSERT;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end else if (cnt_q == REL_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Outputs reflect the state being entered, so they are all flops.
        clr_d  = (state_d == S_ASSERT) || (state_d == S_WAIT_ACK);
        busy_d = (state_d != S_IDLE);
        gate_d = (state_d == S_IDLE);
    end

    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            state_q   <= S_ASSERT;
            cnt_q     <= '0;
            req_dly_q <= 1'b0;
            clr_q     <= 1'b1;
            busy_q    <= 1'b1;
            gate_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_dly_q <= req_s;
            clr_q     <= clr_d;
            busy_q    <= busy_d;
            gate_q    <= gate_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign sync_clr    = clr_q;
    assign rd_rst_busy = busy_q;
    assign rd_en_gate  = gate_q;
    assign rst_done    = done_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_fifo_rd_rst_sequencer.sv
// Scoreboard bench for the read-domain reset sequencer.
// Expected per-cycle output vectors are queued and checked on negedges.
module tb_fifo_rd_rst_sequencer;

    typedef struct packed {
        logic clr;
        logic busy;
        logic gate;
        logic done;
        logic err;
    } vec_t;

    logic s_aclk = 1'b0;
    logic s_aresetn = 1'b1;
    logic wr_rst_req_async = 1'b0;
    logic wr_rst_ack_async = 1'b1;
    logic sw_rst_req = 1'b0;
    logic sync_clr, rd_rst_busy, rd_en_gate, rst_done, err_timeout;

    int   n_vec = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    vec_t exp_q[$];

    fifo_rd_rst_sequencer dut (
        .s_aclk          (s_aclk),
        .s_aresetn       (s_aresetn),
        .wr_rst_req_async(wr_rst_req_async),
        .wr_rst_ack_async(wr_rst_ack_async),
        .sw_rst_req      (sw_rst_req),
        .sync_clr        (sync_clr),
        .rd_rst_busy     (rd_rst_busy),
        .rd_en_gate      (rd_en_gate),
        .rst_done        (rst_done),
        .err_timeout     (err_timeout)
    );

    always #5 s_aclk = ~s_aclk;

    function automatic vec_t obs();
        vec_t v;
        v = '{sync_clr, rd_rst_busy, rd_en_gate, rst_done, err_timeout};
        return v;
    endfunction

    always @(negedge s_aclk) begin
        if (exp_q.size() != 0) begin
            vec_t e;
            vec_t o;
            e = exp_q.pop_front();
            o = obs();
            n_vec++;
            if (rst_done === 1'b1) done_cnt++;
            if (o !== e) begin
                n_err++;
                $display("FAIL out_vec@%0t: got clr/busy/gate/done/err=%b want %b",
                         $time, o, e);
            end
        end
    end

    task automatic push_n(input int n, input vec_t v);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    task automatic push_idle(input int n, input logic err);
        push_n(n, '{1'b0, 1'b0, 1'b1, 1'b0, err});
    endtask

    task automatic push_seq(input int na, input int nw, input int nr,
                            input logic err_rel, input logic tail);
        push_n(na, '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        push_n(nw, '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        push_n(nr, '{1'b0, 1'b1, 1'b0, 1'b0, err_rel});
        if (tail) begin
            exp_q.push_back('{1'b0, 1'b0, 1'b1, 1'b1, err_rel});
            push_idle(1, err_rel);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge s_aclk);
        #1;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge s_aclk);
            #1;
            n++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s drain: %0d entries left, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        vec_t rv;
        s_aresetn = 1'b1;
        #2;
        s_aresetn = 1'b0;
        #1;
        rv = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        n_vec++;
        if (obs() !== rv) begin
            n_err++;
            $display("FAIL reset_vals: got %b want %b", obs(), rv);
        end
    endtask

    task automatic test_power_on(input string name);
        vec_t rv;
        int d0;
        s_aresetn = 1'b0;
        wait_cyc(3);
        #1;
        s_aresetn = 1'b1;
        #1;
        rv = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        n_vec++;
        if (obs() !== rv) begin
            n_err++;
            $display("FAIL %s first_assert: got %b want %b", name, obs(), rv);
        end
        d0 = done_cnt;
        push_seq(7, 1, 3, 1'b0, 1'b1);
        drain(name, 40);
        n_vec++;
        if (done_cnt - d0 !== 1) begin
            n_err++;
            $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt - d0);
        end
    endtask

    task automatic test_sw_req();
        int d0;
        push_idle(2, 1'b0);
        wait_cyc(2);
        d0 = done_cnt;
        sw_rst_req = 1'b1;
        push_seq(8, 1, 3, 1'b0, 1'b1);
        wait_cyc(1);
        sw_rst_req = 1'b0;
        drain("sw_req", 40);
        n_vec++;
        if (done_cnt - d0 !== 1 || err_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL sw_req: got done=%0d err=%b want 1 0",
                     done_cnt - d0, err_timeout);
        end
    endtask

    task automatic test_timeout();
        int d0;
        wr_rst_ack_async = 1'b0;
        push_idle(4, 1'b0);
        wait_cyc(4);
        d0 = done_cnt;
        sw_rst_req = 1'b1;
        push_seq(8, 256, 3, 1'b1, 1'b1);
        wait_cyc(1);
        sw_rst_req = 1'b0;
        drain("timeout", 320);
        wr_rst_ack_async = 1'b1;
        push_idle(4, 1'b1);
        drain("timeout_idle", 10);
        n_vec++;
        if (done_cnt - d0 !== 1 || err_timeout !== 1'b1) begin
            n_err++;
            $display("FAIL timeout: got done=%0d err=%b want 1 1",
                     done_cnt - d0, err_timeout);
        end
    endtask

    task automatic test_release_abort();
        int d0;
        d0 = done_cnt;
        push_seq(8, 1, 2, 1'b0, 1'b0);
        push_seq(8, 1, 3, 1'b0, 1'b1);
        sw_rst_req = 1'b1;
        wait_cyc(1);
        sw_rst_req = 1'b0;
        wait_cyc(10);
        sw_rst_req = 1'b1;
        wait_cyc(1);
        sw_rst_req = 1'b0;
        drain("rel_abort", 40);
        n_vec++;
        if (done_cnt - d0 !== 1) begin
            n_err++;
            $display("FAIL rel_abort done_pulses: got %0d want 1", done_cnt - d0);
        end
    endtask

    task automatic test_simultaneous();
        int d0;
        d0 = done_cnt;
        wr_rst_req_async = 1'b1;
        push_idle(2, 1'b0);
        wait_cyc(2);
        sw_rst_req = 1'b1;
        push_seq(8, 1, 3, 1'b0, 1'b1);
        wait_cyc(1);
        sw_rst_req = 1'b0;
        wr_rst_req_async = 1'b0;
        drain("simul", 40);
        n_vec++;
        if (done_cnt - d0 !== 1) begin
            n_err++;
            $display("FAIL simul done_pulses: got %0d want 1", done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid_wait();
        vec_t rv;
        wr_rst_ack_async = 1'b0;
        push_idle(4, 1'b0);
        wait_cyc(4);
        sw_rst_req = 1'b1;
        push_seq(8, 20, 0, 1'b0, 1'b0);
        wait_cyc(1);
        sw_rst_req = 1'b0;
        drain("mid_wait", 40);
        s_aresetn = 1'b0;
        #1;
        rv = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        n_vec++;
        if (obs() !== rv) begin
            n_err++;
            $display("FAIL mid_wait_reset: got %b want %b", obs(), rv);
        end
        wr_rst_ack_async = 1'b1;
        test_power_on("post_reset");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_power_on("power_on");
        test_sw_req();
        test_timeout();
        test_release_abort();
        test_simultaneous();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
